// File: rtl/limbo_aging_table.sv
`default_nettype none
// ============================================================================
// Module      : limbo_aging_table
// Description : Table of up to DEPTH tags that missed the LIFO/FIFO/CAM
//               lookup. Each entry carries an age counter that advances on
//               tick; entries that reach TIMEOUT become expired and are
//               streamed out over a valid/ready handshake, lowest index first.
//               Supports membership query, purge-by-tag and duplicate/overflow
//               reporting on insert.
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               tick              - age-advance strobe
//               ins_valid/ins_tag - insert request
//               ins_dup/ins_drop  - registered insert outcome pulses
//               query_tag/query_hit - combinational membership of live tags
//               purge_valid/purge_tag/purge_hit - remove-by-tag, hit pulse
//               exp_valid/exp_ready/exp_tag - expired-tag stream
//               count             - occupied entries (live plus expired)
// Revision    : 1.0 - initial release
// ============================================================================
module limbo_aging_table #(
    parameter int TAG_WIDTH = 16,
    parameter int DEPTH     = 8,
    parameter int TIMEOUT   = 100,
    parameter int AGE_W     = $clog2(TIMEOUT + 1),
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 ins_valid,
    input  logic [TAG_WIDTH-1:0] ins_tag,
    output logic                 ins_dup,
    output logic                 ins_drop,
    input  logic [TAG_WIDTH-1:0] query_tag,
    output logic                 query_hit,
    input  logic                 purge_valid,
    input  logic [TAG_WIDTH-1:0] purge_tag,
    output logic                 purge_hit,
    output logic                 exp_valid,
    input  logic                 exp_ready,
    output logic [TAG_WIDTH-1:0] exp_tag,
    output logic [CNT_W-1:0]     count
);

    // Age value from which the next tick makes an entry expire.
    localparam logic [AGE_W-1:0] c_age_last = AGE_W'(TIMEOUT - 1);

    // ------------------------------------------------------------------
    // Entry state
    // ------------------------------------------------------------------
    logic [DEPTH-1:0]     r_valid;
    logic [DEPTH-1:0]     r_expired;
    logic [TAG_WIDTH-1:0] r_tag [DEPTH];
    logic [AGE_W-1:0]     r_age [DEPTH];

    logic r_ins_dup;
    logic r_ins_drop;
    logic r_purge_hit;

    // ------------------------------------------------------------------
    // Per-entry match vectors, all against start-of-cycle state
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] w_query_match;
    logic [DEPTH-1:0] w_ins_match;
    logic [DEPTH-1:0] w_purge_match;
    logic [DEPTH-1:0] w_exp_vec;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry_match
            assign w_query_match[gi] = r_valid[gi] & ~r_expired[gi] & (r_tag[gi] == query_tag);
            assign w_ins_match[gi]   = r_valid[gi] & (r_tag[gi] == ins_tag);
            assign w_purge_match[gi] = purge_valid & r_valid[gi] & (r_tag[gi] == purge_tag);
            assign w_exp_vec[gi]     = r_valid[gi] & r_expired[gi];
        end
    endgenerate

    // Lowest-set-bit isolation (x & -x) picks the lowest-index expired
    // entry and the lowest-index free slot as one-hot vectors.
    logic [DEPTH-1:0] w_free_vec;
    logic [DEPTH-1:0] w_free_oh;
    logic [DEPTH-1:0] w_exp_oh;

    assign w_free_vec = ~r_valid;
    assign w_free_oh  = w_free_vec & (~w_free_vec + DEPTH'(1));
    assign w_exp_oh   = w_exp_vec & (~w_exp_vec + DEPTH'(1));

    logic w_dup_any;
    logic w_has_free;
    logic w_write;
    logic w_drop;
    logic w_pop;

    assign w_dup_any  = |w_ins_match;
    assign w_has_free = |w_free_vec;
    assign w_write    = ins_valid & ~w_dup_any & w_has_free;
    assign w_drop     = ins_valid & ~w_dup_any & ~w_has_free;
    assign w_pop      = exp_valid & exp_ready;

    // Slots being freed were occupied at the start of the cycle, so they are
    // never in w_free_vec and can not collide with the allocation target.
    logic [DEPTH-1:0] w_clear;
    logic [DEPTH-1:0] w_alloc;

    assign w_clear = w_purge_match | (w_pop ? w_exp_oh : '0);
    assign w_alloc = w_write ? w_free_oh : '0;

    // ------------------------------------------------------------------
    // Combinational outputs
    // ------------------------------------------------------------------
    logic [TAG_WIDTH-1:0] w_exp_tag;
    logic [CNT_W-1:0]     w_count;

    always_comb begin
        w_exp_tag = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_exp_oh[i]) begin
                w_exp_tag = w_exp_tag | r_tag[i];
            end
        end
    end

    always_comb begin
        w_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_count = w_count + CNT_W'(r_valid[i]);
        end
    end

    assign query_hit = |w_query_match;
    assign exp_valid = |w_exp_vec;
    assign exp_tag   = w_exp_tag;
    assign count     = w_count;
    assign ins_dup   = r_ins_dup;
    assign ins_drop  = r_ins_drop;
    assign purge_hit = r_purge_hit;

    // ------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= '0;
            r_expired   <= '0;
            r_ins_dup   <= 1'b0;
            r_ins_drop  <= 1'b0;
            r_purge_hit <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_tag[i] <= '0;
                r_age[i] <= '0;
            end
        end else begin
            r_ins_dup   <= ins_valid & w_dup_any;
            r_ins_drop  <= w_drop;
            r_purge_hit <= |w_purge_match;
            for (int i = 0; i < DEPTH; i++) begin
                if (w_clear[i]) begin
                    // Freeing wins over aging on the same cycle.
                    r_valid[i]   <= 1'b0;
                    r_expired[i] <= 1'b0;
                    r_age[i]     <= '0;
                end else if (w_alloc[i]) begin
                    r_valid[i]   <= 1'b1;
                    r_expired[i] <= 1'b0;
                    r_age[i]     <= '0;
                    r_tag[i]     <= ins_tag;
                end else if (tick && r_valid[i] && !r_expired[i]) begin
                    // Age stops at TIMEOUT because expired entries no longer
                    // advance, so the counter can not wrap.
                    r_age[i] <= r_age[i] + AGE_W'(1);
                    if (r_age[i] == c_age_last) begin
                        r_expired[i] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_limbo_aging_table.sv
`default_nettype none
// ============================================================================
// Module      : tb_limbo_aging_table
// Description : Self-checking bench for limbo_aging_table (TIMEOUT=4,
//               DEPTH=8). Table-driven vectors, directed multi-cycle
//               sequences and randomized traffic, every cycle also checked
//               against a slot/tick-count reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_limbo_aging_table;

    localparam int TW  = 16;
    localparam int DP  = 8;
    localparam int TO  = 4;
    localparam int CW  = $clog2(DP + 1);

    logic          clk;
    logic          rst;
    logic          tick;
    logic          ins_valid;
    logic [TW-1:0] ins_tag;
    logic          ins_dup;
    logic          ins_drop;
    logic [TW-1:0] query_tag;
    logic          query_hit;
    logic          purge_valid;
    logic [TW-1:0] purge_tag;
    logic          purge_hit;
    logic          exp_valid;
    logic          exp_ready;
    logic [TW-1:0] exp_tag;
    logic [CW-1:0] count;

    limbo_aging_table #(
        .TAG_WIDTH (TW),
        .DEPTH     (DP),
        .TIMEOUT   (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .ins_valid   (ins_valid),
        .ins_tag     (ins_tag),
        .ins_dup     (ins_dup),
        .ins_drop    (ins_drop),
        .query_tag   (query_tag),
        .query_hit   (query_hit),
        .purge_valid (purge_valid),
        .purge_tag   (purge_tag),
        .purge_hit   (purge_hit),
        .exp_valid   (exp_valid),
        .exp_ready   (exp_ready),
        .exp_tag     (exp_tag),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a slot is either unused or holds a tag and the
    // number of ticks seen since insertion (capped at TO).
    // ------------------------------------------------------------------
    bit          m_used  [DP];
    logic [TW-1:0] m_tag [DP];
    int          m_ticks [DP];

    task automatic model_clear();
        for (int i = 0; i < DP; i++) begin
            m_used[i]  = 1'b0;
            m_tag[i]   = '0;
            m_ticks[i] = 0;
        end
    endtask

    // DUT values sampled by the last apply() call.
    bit          s_qhit, s_ev, s_dup, s_drop, s_phit;
    logic [TW-1:0] s_etag;
    int          s_cnt;

    // One clock cycle: drive inputs, check combinational outputs against the
    // model, clock, check the registered pulses, advance the model.
    task automatic apply(input bit tk, input bit iv, input logic [TW-1:0] it,
                         input logic [TW-1:0] qt, input bit pv,
                         input logic [TW-1:0] pt, input bit er);
        int      first_exp, first_free, cnt;
        bit      present_ins, present_pur, qh;
        logic [TW-1:0] etag;
        bit      freed;

        tick = tk; ins_valid = iv; ins_tag = it; query_tag = qt;
        purge_valid = pv; purge_tag = pt; exp_ready = er;
        #1;
        first_exp = -1; first_free = -1; cnt = 0;
        present_ins = 0; present_pur = 0; qh = 0;
        for (int i = 0; i < DP; i++) begin
            if (m_used[i]) begin
                cnt++;
                if (m_tag[i] == it) present_ins = 1;
                if (m_tag[i] == pt) present_pur = 1;
                if (m_ticks[i] < TO && m_tag[i] == qt) qh = 1;
                if (m_ticks[i] >= TO && first_exp < 0) first_exp = i;
            end else if (first_free < 0) begin
                first_free = i;
            end
        end
        etag = (first_exp >= 0) ? m_tag[first_exp] : '0;

        s_qhit = query_hit; s_ev = exp_valid; s_etag = exp_tag; s_cnt = int'(count);
        chk("m_query_hit", 32'(query_hit), 32'(qh));
        chk("m_exp_valid", 32'(exp_valid), 32'(first_exp >= 0));
        chk("m_exp_tag",   32'(exp_tag),   32'(etag));
        chk("m_count",     32'(count),     32'(cnt));

        @(posedge clk);
        #1;
        s_dup = ins_dup; s_drop = ins_drop; s_phit = purge_hit;
        chk("m_ins_dup",   32'(ins_dup),   32'(iv && present_ins));
        chk("m_ins_drop",  32'(ins_drop),  32'(iv && !present_ins && first_free < 0));
        chk("m_purge_hit", 32'(purge_hit), 32'(pv && present_pur));

        for (int i = 0; i < DP; i++) begin
            if (m_used[i]) begin
                freed = (pv && m_tag[i] == pt) || (er && i == first_exp);
                if (freed) begin
                    m_used[i] = 1'b0;
                end else if (tk && m_ticks[i] < TO) begin
                    m_ticks[i]++;
                end
            end
        end
        if (iv && !present_ins && first_free >= 0) begin
            m_used[first_free]  = 1'b1;
            m_tag[first_free]   = it;
            m_ticks[first_free] = 0;
        end
    endtask

    task automatic idle(input bit tk);
        apply(tk, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic ins(input logic [TW-1:0] t, input bit tk);
        apply(tk, 1'b1, t, '0, 1'b0, '0, 1'b0);
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        bit          tk;
        bit          iv;
        logic [TW-1:0] it;
        logic [TW-1:0] qt;
        bit          pv;
        logic [TW-1:0] pt;
        bit          er;
        bit          e_qhit;
        bit          e_ev;
        logic [TW-1:0] e_etag;
        int          e_cnt;
        bit          e_dup;
        bit          e_drop;
        bit          e_phit;
    } vec_t;

    function automatic vec_t mk(input bit iv, input logic [TW-1:0] it,
                                input logic [TW-1:0] qt, input bit pv,
                                input logic [TW-1:0] pt, input bit e_qhit,
                                input int e_cnt, input bit e_dup,
                                input bit e_drop, input bit e_phit);
        vec_t v;
        v.tk = 1'b0; v.iv = iv; v.it = it; v.qt = qt; v.pv = pv; v.pt = pt;
        v.er = 1'b0; v.e_qhit = e_qhit; v.e_ev = 1'b0; v.e_etag = '0;
        v.e_cnt = e_cnt; v.e_dup = e_dup; v.e_drop = e_drop; v.e_phit = e_phit;
        return v;
    endfunction

    vec_t tbl [20];

    logic [TW-1:0] pop_order [8];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        rst = 1'b1; tick = 0; ins_valid = 0; ins_tag = '0; query_tag = '0;
        purge_valid = 0; purge_tag = '0; exp_ready = 0;
        model_clear();

        //           iv  it      qt      pv  pt      qhit cnt dup drop phit
        tbl[0]  = mk(1, 16'h00A1, 16'h00A1, 0, 16'h0,    0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 16'h00A2, 16'h00A1, 0, 16'h0,    1, 1, 0, 0, 0);
        tbl[2]  = mk(0, 16'h0,    16'h0BAD, 0, 16'h0,    0, 2, 0, 0, 0);
        tbl[3]  = mk(0, 16'h0,    16'h00A2, 0, 16'h0,    1, 2, 0, 0, 0);
        tbl[4]  = mk(0, 16'h0,    16'h00A1, 1, 16'h00A1, 1, 2, 0, 0, 1);
        tbl[5]  = mk(0, 16'h0,    16'h00A1, 1, 16'h00A2, 0, 1, 0, 0, 1);
        tbl[6]  = mk(0, 16'h0,    16'h00A2, 0, 16'h0,    0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++)
            tbl[7 + k] = mk(1, 16'(16'h10 + k), 16'h0, 0, 16'h0, 0, k, 0, 0, 0);
        tbl[15] = mk(1, 16'h0018, 16'h0,    0, 16'h0,    0, 8, 0, 1, 0);
        tbl[16] = mk(1, 16'h0013, 16'h0,    0, 16'h0,    0, 8, 1, 0, 0);
        tbl[17] = mk(0, 16'h0,    16'h0013, 1, 16'h0013, 1, 8, 0, 0, 1);
        tbl[18] = mk(1, 16'h0040, 16'h0013, 0, 16'h0,    0, 7, 0, 0, 0);
        tbl[19] = mk(0, 16'h0,    16'h0040, 0, 16'h0,    1, 8, 0, 0, 0);

        pop_order[0] = 16'h10; pop_order[1] = 16'h11; pop_order[2] = 16'h12;
        pop_order[3] = 16'h40; pop_order[4] = 16'h14; pop_order[5] = 16'h15;
        pop_order[6] = 16'h16; pop_order[7] = 16'h17;

        // Reset state
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_exp_valid", 32'(exp_valid), 0);
        chk("rst_exp_tag", 32'(exp_tag), 0);
        chk("rst_pulses", {29'd0, ins_dup, ins_drop, purge_hit}, 0);
        @(posedge clk); @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;

        // Table vectors: basic insert/query/purge, fill, drop, dup, reuse
        for (int k = 0; k < 20; k++) begin
            apply(tbl[k].tk, tbl[k].iv, tbl[k].it, tbl[k].qt, tbl[k].pv, tbl[k].pt, tbl[k].er);
            chk($sformatf("tbl%0d_qhit", k), 32'(s_qhit), 32'(tbl[k].e_qhit));
            chk($sformatf("tbl%0d_ev", k),   32'(s_ev),   32'(tbl[k].e_ev));
            chk($sformatf("tbl%0d_etag", k), 32'(s_etag), 32'(tbl[k].e_etag));
            chk($sformatf("tbl%0d_cnt", k),  32'(s_cnt),  32'(tbl[k].e_cnt));
            chk($sformatf("tbl%0d_dup", k),  32'(s_dup),  32'(tbl[k].e_dup));
            chk($sformatf("tbl%0d_drop", k), 32'(s_drop), 32'(tbl[k].e_drop));
            chk($sformatf("tbl%0d_phit", k), 32'(s_phit), 32'(tbl[k].e_phit));
        end

        // All eight aged together; pop order exposes slot 3 holding 0x40
        for (int k = 0; k < TO; k++) idle(1'b1);
        for (int k = 0; k < 8; k++) begin
            apply(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
            chk("pop_order_ev", 32'(s_ev), 1);
            chk("pop_order_tag", 32'(s_etag), 32'(pop_order[k]));
        end
        idle(1'b0);
        chk("pop_all_cnt", 32'(s_cnt), 0);

        // Expiry exactly TIMEOUT ticks after insert, stable until popped
        ins(16'h1234, 1'b1);
        for (int k = 0; k < TO; k++) begin
            apply(1'b1, 1'b0, '0, 16'h1234, 1'b0, '0, 1'b0);
            chk("early_ev", 32'(s_ev), 0);
            chk("early_qhit", 32'(s_qhit), 1);
        end
        for (int k = 0; k < 3; k++) begin
            apply(1'b1, 1'b0, '0, 16'h1234, 1'b0, '0, 1'b0);
            chk("exp_ev", 32'(s_ev), 1);
            chk("exp_tag_hold", 32'(s_etag), 32'h1234);
            chk("exp_qhit", 32'(s_qhit), 0);
        end
        apply(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b1);
        idle(1'b1);
        chk("exp_pop_cnt", 32'(s_cnt), 0);

        // Two simultaneous expiries, pop then purge of the presented entry
        ins(16'h20, 1'b0);
        ins(16'h21, 1'b0);
        for (int k = 0; k < TO; k++) idle(1'b1);
        apply(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
        chk("two_first", 32'(s_etag), 32'h20);
        apply(1'b0, 1'b0, '0, '0, 1'b1, 16'h21, 1'b0);
        chk("two_second", 32'(s_etag), 32'h21);
        chk("two_purge_hit", 32'(s_phit), 1);
        idle(1'b0);
        chk("two_ev_gone", 32'(s_ev), 0);

        // Full table: pop+purge of presented 0x30 with insert 0x31 dropped
        ins(16'h30, 1'b0);
        for (int k = 0; k < TO; k++) idle(1'b1);
        for (int k = 0; k < 7; k++) ins(16'(16'h60 + k), 1'b0);
        apply(1'b0, 1'b1, 16'h31, '0, 1'b1, 16'h30, 1'b1);
        chk("sim_cnt_pre", 32'(s_cnt), 8);
        chk("sim_etag", 32'(s_etag), 32'h30);
        chk("sim_drop", 32'(s_drop), 1);
        chk("sim_phit", 32'(s_phit), 1);
        idle(1'b0);
        chk("sim_cnt_post", 32'(s_cnt), 7);
        for (int k = 0; k < 7; k++) apply(1'b0, 1'b0, '0, '0, 1'b1, 16'(16'h60 + k), 1'b0);

        // Insert and purge of the same present tag in one cycle
        ins(16'h55, 1'b0);
        apply(1'b0, 1'b1, 16'h55, '0, 1'b1, 16'h55, 1'b0);
        chk("ip_dup", 32'(s_dup), 1);
        chk("ip_phit", 32'(s_phit), 1);
        idle(1'b0);
        chk("ip_cnt", 32'(s_cnt), 0);

        // Asynchronous reset with five entries, two expired
        ins(16'h70, 1'b0);
        ins(16'h71, 1'b0);
        for (int k = 0; k < TO; k++) idle(1'b1);
        ins(16'h72, 1'b0);
        ins(16'h73, 1'b0);
        ins(16'h74, 1'b0);
        ins(16'h73, 1'b0);
        ins_valid = 0; query_tag = 16'h72;
        #2 rst = 1'b1;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_exp_valid", 32'(exp_valid), 0);
        chk("arst_exp_tag", 32'(exp_tag), 0);
        chk("arst_ins_dup", 32'(ins_dup), 0);
        chk("arst_qhit", 32'(query_hit), 0);
        model_clear();
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < TO + 2; k++) idle(1'b1);
        chk("arst_after_ev", 32'(s_ev), 0);
        chk("arst_after_cnt", 32'(s_cnt), 0);

        // Randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            apply(1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 99) < 55),
                  16'(16'h0050 + $urandom_range(0, 11)),
                  16'(16'h0050 + $urandom_range(0, 11)),
                  1'($urandom_range(0, 99) < 15),
                  16'(16'h0050 + $urandom_range(0, 11)),
                  1'($urandom_range(0, 99) < 30));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
